// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: filters the multiplexed anode/segment lines, decodes each stable digit back to hex and tracks frame/scan health.
module seg7_scan_capture #(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  digit_vld,
  output logic [3:0]  digit_blank,
  output logic        pat_err,
  output logic        frame_done,
  output logic        scan_lost
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  // Active-high gfedcba glyphs, entry k at bits [7k+:7]
  localparam logic [111:0] LUT = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                  7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [10:0]   samp;
  logic [7:0]    stab_cnt;
  logic          armed;
  logic [3:0]    frame_mask;
  logic [TW-1:0] to_cnt;
  logic          cap, hit, blank;
  logic [3:0]    nib, sel, mask_nx;
  logic [1:0]    idx;
  logic [6:0]    pat;
  always_comb begin
    pat = ~samp[6:0];
    sel = ~samp[10:7];
    cap = stab_cnt == 8'(STABLE_CYC - 1) && armed && $onehot(sel);
    idx = 2'd0;
    for (int k = 0; k < 4; k++) if (sel[k]) idx = 2'(k);
    hit = 1'b0;
    nib = 4'd0;
    for (int k = 0; k < 16; k++)
      if (pat == LUT[7*k +: 7]) begin
        hit = 1'b1;
        nib = 4'(k);
      end
    blank   = pat == 7'd0;
    mask_nx = frame_mask | sel;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp        <= '1;
      stab_cnt    <= '0;
      armed       <= 1'b1;
      frame_mask  <= '0;
      to_cnt      <= '0;
      digits      <= '0;
      digit_vld   <= '0;
      digit_blank <= '0;
      pat_err     <= 1'b0;
      frame_done  <= 1'b0;
      scan_lost   <= 1'b0;
    end else begin
      pat_err    <= 1'b0;
      frame_done <= 1'b0;
      if (cap) begin
        armed       <= 1'b0;
        to_cnt      <= '0;
        scan_lost   <= 1'b0;
        if (hit) digits[{idx, 2'b00} +: 4] <= nib;
        digit_vld[idx]   <= hit;
        digit_blank[idx] <= blank;
        pat_err          <= !hit && !blank;
        frame_mask       <= mask_nx == 4'hF ? 4'h0 : mask_nx;
        frame_done       <= mask_nx == 4'hF;
      end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
        scan_lost  <= 1'b1;
        digit_vld  <= '0;
        frame_mask <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
      // A changed input opens a new window, re-arming even on a capture edge
      samp <= {an, seg};
      if ({an, seg} == samp) begin
        if (stab_cnt != 8'(STABLE_CYC - 1)) stab_cnt <= stab_cnt + 8'd1;
      end else begin
        stab_cnt <= '0;
        armed    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: random and directed scans checked every cycle against a run-length reference model.
module tb_seg7_scan_capture;
  localparam int SC = 4, TO = 64;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  an = '1;
  logic [6:0]  seg = '1;
  logic [15:0] digits;
  logic [3:0]  digit_vld, digit_blank;
  logic        pat_err, frame_done, scan_lost;
  always #5 clk = ~clk;
  seg7_scan_capture #(.STABLE_CYC(SC), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .digits(digits), .digit_vld(digit_vld),
    .digit_blank(digit_blank), .pat_err(pat_err), .frame_done(frame_done), .scan_lost(scan_lost)
  );
  logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int n_chk = 0, n_pass = 0;
  logic [15:0] m_digits;
  logic [3:0]  m_vld, m_blank, m_mask;
  logic        m_pe, m_fd, m_lost, pend;
  logic [10:0] prev;
  int          age, run;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask
  function automatic logic [6:0] enc(input int d);
    return ~hex7[d];
  endfunction
  task automatic model_reset();
    m_digits = '0; m_vld = '0; m_blank = '0; m_mask = '0;
    m_pe = 0; m_fd = 0; m_lost = 0; pend = 0;
    prev = '1; run = 1; age = 0;
  endtask
  // A digit is taken once per run of exactly SC identical samples with one anode low
  task automatic model_edge(input logic [10:0] v);
    int i, h;
    logic [6:0] p;
    m_pe = 0; m_fd = 0;
    if (pend) begin
      i = 0;
      for (int k = 0; k < 4; k++) if (!prev[7+k]) i = k;
      p = ~prev[6:0];
      h = -1;
      for (int k = 0; k < 16; k++) if (hex7[k] == p) h = k;
      if (h >= 0) begin m_digits[4*i +: 4] = 4'(h); m_vld[i] = 1; m_blank[i] = 0; end
      else if (p == 0) begin m_vld[i] = 0; m_blank[i] = 1; end
      else begin m_vld[i] = 0; m_blank[i] = 0; m_pe = 1; end
      m_mask[i] = 1;
      if (m_mask == 4'hF) begin m_fd = 1; m_mask = 0; end
      age = 0; m_lost = 0;
    end else begin
      age++;
      if (age >= TO) begin m_lost = 1; m_vld = 0; m_mask = 0; end
    end
    run  = (v == prev) ? run + 1 : 1;
    prev = v;
    pend = run == SC && $countones(~v[10:7]) == 1;
  endtask
  task automatic compare();
    chk("digits", 32'(digits), 32'(m_digits));
    chk("digit_vld", 32'(digit_vld), 32'(m_vld));
    chk("digit_blank", 32'(digit_blank), 32'(m_blank));
    chk("pat_err", 32'(pat_err), 32'(m_pe));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("scan_lost", 32'(scan_lost), 32'(m_lost));
  endtask
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge({an, seg});
    #1 compare();
  endtask
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a; seg = s;
    repeat (n) step();
  endtask
  task automatic rand_scan(input int chunks);
    int d;
    for (int n = 0; n < chunks; n++) begin
      d = $urandom_range(0, 99);
      an = ~(4'b1 << $urandom_range(0, 3));
      if (d < 5) an = '1;
      else if (d < 10) an = 4'($urandom);
      d = $urandom_range(0, 99);
      seg = d < 80 ? enc($urandom_range(0, 15)) : d < 88 ? 7'h7F : 7'($urandom);
      if ($urandom_range(0, 49) == 0) hold(4'hF, 7'h7F, $urandom_range(60, 75));
      else repeat ($urandom_range(1, 10)) step();
    end
  endtask
  initial begin
    model_reset();
    #1 compare();
    repeat (2) step();
    #2 rst_n = 1'b1;
    hold(4'b1110, enc(2), 12);
    chk("single_digit0", 32'(digits[3:0]), 32'h2);
    for (int n = 0; n < 5; n++) begin
      hold(4'b1101, enc(7), 2);
      hold(4'b1101, enc(8), 2);
    end
    hold(4'b1101, enc(8), 6);
    chk("glitch_digit1", 32'(digits[7:4]), 32'h8);
    hold(4'b1110, enc(1), 8);
    hold(4'b1101, enc(10), 8);
    hold(4'b1011, enc(5), 8);
    hold(4'b0111, enc(15), 8);
    chk("frame_value", 32'(digits), 32'hF5A1);
    hold(4'b1011, 7'h7F, 8);
    hold(4'b0111, 7'b0110110, 8);
    hold(4'b1111, 7'h7F, 80);
    hold(4'b1110, enc(3), 8);
    rand_scan(150);
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare();
    repeat (2) step();
    #2 rst_n = 1'b1;
    rand_scan(150);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
